// File: rtl/game_pkg.sv
// Shared game-core constants: coordinate width, screen size and projectile FSM state codes.
package game_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Projectile FSM state encodings
  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StFly      = 2'd1;
  localparam logic [1:0] StCooldown = 2'd2;

endpackage

// File: rtl/projectile_controller_if.sv
// Projectile controller bus: game tick, fire, shooter position and collision in;
// projectile position, activity and hit/miss pulses out.
// PROJ_HIT_COUNTER_EN adds clr_count and hit_count.
interface projectile_controller_if;
  import game_pkg::*;

  logic               clk_collision;
  logic               fire;
  logic [COORD_W-1:0] shooter_x;
  logic [COORD_W-1:0] shooter_y;
  logic               collision;
  logic [COORD_W-1:0] proj_x;
  logic [COORD_W-1:0] proj_y;
  logic               proj_active;
  logic               hit;
  logic               miss;
`ifdef PROJ_HIT_COUNTER_EN
  logic               clr_count;
  logic [15:0]        hit_count;

  modport master (
    input  clk_collision, fire, shooter_x, shooter_y, collision, clr_count,
    output proj_x, proj_y, proj_active, hit, miss, hit_count
  );

  modport slave (
    output clk_collision, fire, shooter_x, shooter_y, collision, clr_count,
    input  proj_x, proj_y, proj_active, hit, miss, hit_count
  );
`else
  modport master (
    input  clk_collision, fire, shooter_x, shooter_y, collision,
    output proj_x, proj_y, proj_active, hit, miss
  );

  modport slave (
    output clk_collision, fire, shooter_x, shooter_y, collision,
    input  proj_x, proj_y, proj_active, hit, miss
  );
`endif

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector with synchronous active-low reset; rise_o is combinational
// so the edge is seen in the same cycle the level first goes high.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember last cycle's level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/projectile_controller.sv
// Player projectile controller: launches on a fire edge, climbs one PROJ_SPEED step per
// game tick, retires on an armed collision or on leaving the top edge, then cools down.
// Optional macro PROJ_HIT_COUNTER_EN adds a saturating hit counter with synchronous clear.
module projectile_controller
  import game_pkg::*;
#(
  parameter int unsigned PROJ_SPEED     = 4,
  parameter int unsigned SHOOTER_HALF_W = 8,
  parameter int unsigned COOLDOWN_TICKS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  projectile_controller_if.master bus
);

  localparam logic [COORD_W-1:0] Speed    = COORD_W'(PROJ_SPEED);
  localparam logic [COORD_W-1:0] HalfW    = COORD_W'(SHOOTER_HALF_W);
  localparam logic [7:0]         CoolLoad = 8'(COOLDOWN_TICKS);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               active_q, active_d;
  logic               armed_q, armed_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               fire_rise;

  edge_detect u_fire_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .sig_i  (bus.fire),
    .rise_o (fire_rise)
  );

  // Next-state logic; armed blocks collision until the first move, since the
  // detector answers one clk after the tick that moved us.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (fire_rise) begin
          x_d      = bus.shooter_x + HalfW;
          y_d      = bus.shooter_y;
          active_d = 1'b1;
          armed_d  = 1'b0;
          state_d  = StFly;
        end
      end
      StFly: begin
        if (bus.collision && armed_q) begin
          // Hit outranks a coincident tick: no move, no miss
          hit_d    = 1'b1;
          active_d = 1'b0;
          armed_d  = 1'b0;
          cnt_d    = CoolLoad;
          state_d  = StCooldown;
        end else if (bus.clk_collision) begin
          if (y_q < Speed) begin
            miss_d   = 1'b1;
            active_d = 1'b0;
            armed_d  = 1'b0;
            cnt_d    = CoolLoad;
            state_d  = StCooldown;
          end else begin
            y_d     = y_q - Speed;
            armed_d = 1'b1;
          end
        end
      end
      StCooldown: begin
        if (bus.clk_collision) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        active_d = 1'b0;
        armed_d  = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= 8'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.proj_x      = x_q;
  assign bus.proj_y      = y_q;
  assign bus.proj_active = active_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;

`ifdef PROJ_HIT_COUNTER_EN
  logic [15:0] hit_count_q, hit_count_d;

  // Saturating hit count, clear wins over increment; bumps alongside the hit pulse
  always_comb begin
    hit_count_d = hit_count_q;
    if (bus.clr_count) begin
      hit_count_d = 16'd0;
    end else if (hit_d && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
  end

  // Hit count register
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q <= 16'd0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign bus.hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_projectile_controller.sv
// Scoreboard bench for projectile_controller: stimulus queues expected launch/move/
// hit/miss/abort events, a negedge monitor classifies what the DUT shows and compares.
module tb_projectile_controller;
  import game_pkg::*;

  localparam logic [2:0] EvLaunch = 3'd0;
  localparam logic [2:0] EvMove   = 3'd1;
  localparam logic [2:0] EvHit    = 3'd2;
  localparam logic [2:0] EvMiss   = 3'd3;
  localparam logic [2:0] EvAbort  = 3'd4;

  typedef struct packed {
    logic [2:0]         kind;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  projectile_controller_if bus ();

  projectile_controller #(
    .PROJ_SPEED     (4),
    .SHOOTER_HALF_W (8),
    .COOLDOWN_TICKS (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t                exp_q[$];
  int                 n_vec = 0;
  int                 n_err = 0;
  logic               prev_active = 1'b0;
  logic [COORD_W-1:0] prev_x = '0;
  logic [COORD_W-1:0] prev_y = '0;

  function automatic void expect_ev(input logic [2:0] kind, input int x, input int y);
    ev_t e;
    e.kind = kind;
    e.x    = COORD_W'(x);
    e.y    = COORD_W'(y);
    exp_q.push_back(e);
  endfunction

  task automatic score(input logic [2:0] kind);
    ev_t got;
    ev_t e;
    got.kind = kind;
    got.x    = bus.proj_x;
    got.y    = bus.proj_y;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d x=%0d y=%0d, required no event at %0t",
               got.kind, got.x, got.y, $time);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL event: got kind=%0d x=%0d y=%0d, required kind=%0d x=%0d y=%0d at %0t",
                 got.kind, got.x, got.y, e.kind, e.x, e.y, $time);
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: classify observable DUT behaviour each negedge
  always @(negedge clk) begin
    if (bus.hit === 1'b1 && bus.miss === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL hit_miss_exclusive: got both high, required at most one at %0t", $time);
    end
    if (bus.hit === 1'b1) begin
      score(EvHit);
    end else if (bus.miss === 1'b1) begin
      score(EvMiss);
    end else if (bus.proj_active === 1'b1 && !prev_active) begin
      score(EvLaunch);
    end else if (bus.proj_active !== 1'b1 && prev_active) begin
      score(EvAbort);
    end else if (bus.proj_active === 1'b1 &&
                 (bus.proj_x !== prev_x || bus.proj_y !== prev_y)) begin
      score(EvMove);
    end
    prev_active = (bus.proj_active === 1'b1);
    prev_x      = bus.proj_x;
    prev_y      = bus.proj_y;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.clk_collision = 1'b1;
    cycle();
    bus.clk_collision = 1'b0;
  endtask

  task automatic fire_pulse();
    bus.fire = 1'b1;
    cycle();
    bus.fire = 1'b0;
    cycle();
  endtask

  task automatic collide();
    bus.collision = 1'b1;
    cycle();
    bus.collision = 1'b0;
  endtask

  task automatic set_shooter(input int x, input int y);
    bus.shooter_x = COORD_W'(x);
    bus.shooter_y = COORD_W'(y);
  endtask

  initial begin
    bus.clk_collision = 1'b0;
    bus.fire          = 1'b0;
    bus.collision     = 1'b0;
    set_shooter(0, 0);
`ifdef PROJ_HIT_COUNTER_EN
    bus.clr_count = 1'b0;
`endif

    // Reset state
    repeat (3) cycle();
    check("rst_proj_x", 16'(bus.proj_x), 16'd0);
    check("rst_proj_y", 16'(bus.proj_y), 16'd0);
    check("rst_active", 16'(bus.proj_active), 16'd0);
    check("rst_hit", 16'(bus.hit), 16'd0);
    check("rst_miss", 16'(bus.miss), 16'd0);
`ifdef PROJ_HIT_COUNTER_EN
    check("rst_hit_count", bus.hit_count, 16'd0);
`endif
    rst = 1'b1;
    cycle();

    // Launch and flight
    set_shooter(300, 440);
    expect_ev(EvLaunch, 308, 440);
    fire_pulse();
    check("launch_active", 16'(bus.proj_active), 16'd1);
    for (int i = 1; i <= 10; i++) begin
      expect_ev(EvMove, 308, 440 - 4 * i);
      tick();
    end
    check("flight_y", 16'(bus.proj_y), 16'd400);

    // Armed hit, then one-clk pulse
    expect_ev(EvHit, 308, 400);
    collide();
    check("hit_pulse", 16'(bus.hit), 16'd1);
    check("hit_active", 16'(bus.proj_active), 16'd0);
    cycle();
    check("hit_one_clk", 16'(bus.hit), 16'd0);

    // Cooldown: collisions and fire are ignored
    collide();
    tick();
    tick();
    fire_pulse();
    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    repeat (5) tick();
    collide();

    // Fire held throughout; collision on launch and while unarmed is ignored
    set_shooter(100, 20);
    expect_ev(EvLaunch, 108, 20);
    bus.fire      = 1'b1;
    bus.collision = 1'b1;
    cycle();
    cycle();
    expect_ev(EvMove, 108, 16);
    tick();
    expect_ev(EvHit, 108, 16);
    tick();
    bus.collision = 1'b0;
    repeat (8) tick();
    repeat (3) cycle();
    bus.fire = 1'b0;
    cycle();

    // Miss with x wrap; fire one tick before cooldown ends is dropped
    set_shooter(1020, 6);
    expect_ev(EvLaunch, 4, 6);
    fire_pulse();
    expect_ev(EvMove, 4, 2);
    tick();
    expect_ev(EvMiss, 4, 2);
    tick();
    repeat (7) tick();
    fire_pulse();
    tick();

    // Boundary: y == speed moves to 0, then misses
    set_shooter(50, 4);
    expect_ev(EvLaunch, 58, 4);
    fire_pulse();
    expect_ev(EvMove, 58, 0);
    tick();
    expect_ev(EvMiss, 58, 0);
    tick();
    repeat (8) tick();

    // Third hit
    set_shooter(200, 300);
    expect_ev(EvLaunch, 208, 300);
    fire_pulse();
    expect_ev(EvMove, 208, 296);
    tick();
    expect_ev(EvHit, 208, 296);
    collide();
    repeat (8) tick();
`ifdef PROJ_HIT_COUNTER_EN
    check("hit_count_3", bus.hit_count, 16'd3);
    bus.clr_count = 1'b1;
    cycle();
    bus.clr_count = 1'b0;
    check("hit_count_clr", bus.hit_count, 16'd0);
`endif

    // Reset mid-flight aborts silently
    set_shooter(10, 100);
    expect_ev(EvLaunch, 18, 100);
    fire_pulse();
    expect_ev(EvMove, 18, 96);
    tick();
    expect_ev(EvAbort, 0, 0);
    rst = 1'b0;
    cycle();
    check("abort_active", 16'(bus.proj_active), 16'd0);
    check("abort_hit", 16'(bus.hit), 16'd0);
    check("abort_miss", 16'(bus.miss), 16'd0);
    rst = 1'b1;
    repeat (3) cycle();

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event: got none, required kind=%0d x=%0d y=%0d", e.kind, e.x, e.y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
